// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - pipelined instruction fetch unit with prefetch FIFO
//
// Issues in-order, word-aligned fetches on the instruction bus and allows
// several requests to be outstanding. Responses go into a DEPTH-entry FIFO
// that feeds the ID stage. A flush drops buffered entries and discards the
// responses that are still in flight. A bus error halts fetching until the
// next flush.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush_i, flush_addr_i           redirect fetch to flush_addr_i (word aligned)
//   id_ready_i                      ID consumes the head entry this cycle
//   inst_o, pc_o, inst_err_o        head entry (NOP / 0 / 0 when empty)
//   inst_valid_o                    FIFO holds at least one entry
//   instr_req_o, instr_addr_o       bus address phase
//   instr_gnt_i                     address phase accepted
//   instr_rvalid_i, instr_rdata_i,
//   instr_err_i                     in-order response phase

module ifu_prefetch #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        id_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_err_o,
    output logic        inst_valid_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = RESET_ADDR & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_HALT
    } state_t;

    state_t        state;
    logic [31:0]   req_addr;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [31:0] fifo_inst [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];
    logic        fifo_err  [DEPTH];

    logic        grant;
    logic        push;
    logic        drop;
    logic        pop;
    logic [CW:0] credit_used;
    logic [31:0] flush_target;

    // Outstanding requests and buffered entries share one budget, so every
    // response that comes back always has a free FIFO slot.
    assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign instr_req_o  = (state == S_RUN) && !flush_i && (credit_used < DEPTH_C);
    assign instr_addr_o = req_addr;
    assign grant        = instr_req_o && instr_gnt_i;

    // Responses arriving while discard is non-zero belong to a fetch stream
    // that was abandoned by an earlier flush.
    assign push = instr_rvalid_i && !flush_i && (discard == '0);
    assign drop = instr_rvalid_i && !flush_i && (discard != '0);
    assign pop  = inst_valid_o && id_ready_i && !flush_i;

    assign flush_target = flush_addr_i & 32'hFFFF_FFFC;

    assign inst_valid_o = (fifo_count != '0);
    assign inst_o       = inst_valid_o ? fifo_inst[rd_ptr] : NOP;
    assign pc_o         = inst_valid_o ? fifo_pc[rd_ptr] : 32'h0;
    assign inst_err_o   = inst_valid_o && fifo_err[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET: state <= S_RUN;
                S_RUN: begin
                    if (flush_i) begin
                        state <= S_RUN;
                    end else if (push && instr_err_i) begin
                        state <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (flush_i) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            // A grant and a response in the same cycle cancel out.
            outstanding <= outstanding + CW'(grant) - CW'(instr_rvalid_i);

            if (flush_i) begin
                req_addr   <= flush_target;
                resp_pc    <= flush_target;
                // Every response still in flight after this cycle belongs to
                // the old stream; one arriving this cycle is dropped here.
                discard    <= outstanding - CW'(instr_rvalid_i);
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                if (grant) begin
                    req_addr <= req_addr + 32'd4;
                end
                if (drop) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // Entry storage needs no reset: fifo_count qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= instr_rdata_i;
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_err[wr_ptr]  <= instr_err_i;
        end
    end

    // The bus is strictly in-order and never answers an unissued request.
    rvalid_needs_request: assert property (
        @(posedge clk) disable iff (!rst_n) instr_rvalid_i |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - self-checking bench for ifu_prefetch

module tb_ifu_prefetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_addr = 32'h0;
    logic        id_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_err;
    logic        inst_valid;
    logic        req;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] addr;
    logic [31:0] rdata = 32'h0;
    logic        rerr = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int grant_cnt = 0;

    bit          resp_en = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        err;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    bit   pend_v = 1'b0;
    bus_t pend;

    ifu_prefetch #(.DEPTH(4), .RESET_ADDR(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .flush_addr_i  (flush_addr),
        .id_ready_i    (id_ready),
        .inst_o        (inst),
        .pc_o          (pc),
        .inst_err_o    (inst_err),
        .inst_valid_o  (inst_valid),
        .instr_req_o   (req),
        .instr_gnt_i   (gnt),
        .instr_rvalid_i(rvalid),
        .instr_addr_o  (addr),
        .instr_rdata_i (rdata),
        .instr_err_i   (rerr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // Scoreboard: every grant since the last flush must come out in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req && gnt) begin
                pend_v    = 1'b1;
                pend.addr = addr;
                pend.err  = err_en && (addr == err_addr);
                grant_cnt++;
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (inst_valid) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL stale_inst: pc_o=%h valid with nothing expected", pc);
                    end else if ({pc, inst, inst_err} !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL head_entry: got pc=%h inst=%h err=%b expected pc=%h inst=%h err=%b",
                                 pc, inst, inst_err, exp_q[0].pc, exp_q[0].inst, exp_q[0].err);
                    end
                    if (id_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (req && gnt) exp_q.push_back({addr, mem_data(addr), err_en && (addr == err_addr)});
            end
        end
    end

    // In-order bus responder with one cycle of response latency.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            bus_q.delete();
            pend_v = 1'b0;
            rvalid = 1'b0;
            rdata  = 32'h0;
            rerr   = 1'b0;
        end else begin
            if (rvalid) void'(bus_q.pop_front());
            if (pend_v) begin
                bus_q.push_back(pend);
                pend_v = 1'b0;
            end
            rvalid = resp_en && (bus_q.size() > 0);
            if (rvalid) begin
                rdata = mem_data(bus_q[0].addr);
                rerr  = bus_q[0].err;
            end else begin
                rdata = 32'hDEAD_BEEF;
                rerr  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_flush(input logic [31:0] a);
        tick();
        flush = 1'b1;
        flush_addr = a;
        tick();
        flush = 1'b0;
    endtask

    // Waits for the next visible entry; returns 0 on timeout.
    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) found = 1'b1;
        end
    endtask

    task automatic test_reset_startup();
        logic        rq [1:9];
        logic        vl [1:9];
        logic [31:0] ad [1:9];
        logic [31:0] pcs[1:9];
        int lat;
        int gaps;
        rst_n = 1'b0; gnt = 1'b1; resp_en = 1'b1; id_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({req, inst_valid, inst, pc, inst_err} !== {1'b0, 1'b0, NOP, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b valid=%b inst=%h pc=%h err=%b expected 0 0 %h 0 0",
                     req, inst_valid, inst, pc, inst_err, NOP);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            rq[i] = req; vl[i] = inst_valid; ad[i] = addr; pcs[i] = pc;
        end
        vectors++;
        if (rq[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL req_in_reset_state: got %b expected 0", rq[1]);
        end
        lat = 0;
        for (int i = 9; i >= 1; i--) if (vl[i]) lat = i;
        vectors++;
        if (lat != 4) begin
            miscompares++;
            $display("FAIL startup_latency: first valid at sample %0d expected 4", lat);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({rq[2+k], ad[2+k]} !== {1'b1, 32'(4 * k)}) begin
                miscompares++;
                $display("FAIL addr_stream: got req=%b addr=%h expected 1 %h", rq[2+k], ad[2+k], 32'(4 * k));
            end
            vectors++;
            if (pcs[4+k] !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL pc_stream: got %h expected %h", pcs[4+k], 32'(4 * k));
            end
        end
        gaps = 0;
        for (int i = 4; i <= 9; i++) if (!vl[i]) gaps++;
        vectors++;
        if (gaps != 0) begin
            miscompares++;
            $display("FAIL back_to_back: %0d empty cycles expected 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        int g0;
        bit req_seen;
        gnt = 1'b0; id_ready = 1'b0; resp_en = 1'b1;
        do_flush(32'h80);
        repeat (6) tick();
        g0 = grant_cnt;
        gnt = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        vectors++;
        if ({grant_cnt - g0, req} !== {32'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL credit_limit: got grants=%0d req=%b expected 4 0", grant_cnt - g0, req);
        end
        tick();
        id_ready = 1'b1;
        req_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (req) req_seen = 1'b1;
            vectors++;
            if ({inst_valid, pc} !== {1'b1, 32'h80 + 32'(4 * k)}) begin
                miscompares++;
                $display("FAIL drain_order: got valid=%b pc=%h expected 1 %h", inst_valid, pc, 32'h80 + 32'(4 * k));
            end
        end
        vectors++;
        if (!req_seen) begin
            miscompares++;
            $display("FAIL req_resume: got no request expected one while draining");
        end
    endtask

    task automatic test_flush_inflight();
        int g0;
        bit found;
        gnt = 1'b0; id_ready = 1'b1; resp_en = 1'b1;
        do_flush(32'h1000);
        repeat (6) tick();
        resp_en = 1'b0;
        g0 = grant_cnt;
        gnt = 1'b1;
        repeat (3) tick();
        gnt = 1'b0;
        flush = 1'b1; flush_addr = 32'h0000_0103; resp_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (grant_cnt - g0 != 3) begin
            miscompares++;
            $display("FAIL outstanding_setup: got %0d grants expected 3", grant_cnt - g0);
        end
        tick();
        flush = 1'b0; gnt = 1'b1;
        wait_valid(found);
        vectors++;
        if ({found, pc, inst} !== {1'b1, 32'h100, mem_data(32'h100)}) begin
            miscompares++;
            $display("FAIL flush_target: got found=%b pc=%h inst=%h expected 1 100 %h",
                     found, pc, inst, mem_data(32'h100));
        end
    endtask

    task automatic test_flush_with_rvalid();
        bit found;
        gnt = 1'b0; id_ready = 1'b1; resp_en = 1'b1;
        do_flush(32'h2000);
        repeat (6) tick();
        resp_en = 1'b0;
        gnt = 1'b1;
        repeat (2) tick();
        gnt = 1'b0; resp_en = 1'b1;
        tick();
        flush = 1'b1; flush_addr = 32'h200;
        @(negedge clk);
        vectors++;
        if ({rvalid, req} !== 2'b10) begin
            miscompares++;
            $display("FAIL req_during_flush: got rvalid=%b req=%b expected 1 0", rvalid, req);
        end
        tick();
        flush = 1'b0; gnt = 1'b1;
        wait_valid(found);
        vectors++;
        if ({found, pc, inst} !== {1'b1, 32'h200, mem_data(32'h200)}) begin
            miscompares++;
            $display("FAIL flush_rvalid_target: got found=%b pc=%h inst=%h expected 1 200 %h",
                     found, pc, inst, mem_data(32'h200));
        end
        repeat (6) tick();
    endtask

    task automatic test_bus_error();
        bit found;
        int req_cycles;
        gnt = 1'b0; id_ready = 1'b1; resp_en = 1'b1; err_en = 1'b1; err_addr = 32'h8;
        do_flush(32'h0);
        repeat (6) tick();
        gnt = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (inst_valid && inst_err) found = 1'b1;
        end
        vectors++;
        if ({found, pc, req} !== {1'b1, 32'h8, 1'b0}) begin
            miscompares++;
            $display("FAIL error_entry: got found=%b pc=%h req=%b expected 1 8 0", found, pc, req);
        end
        req_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            if (req) req_cycles++;
        end
        vectors++;
        if (req_cycles != 0) begin
            miscompares++;
            $display("FAIL halt_no_req: got %0d request cycles expected 0", req_cycles);
        end
        err_en = 1'b0;
        do_flush(32'h40);
        @(negedge clk);
        vectors++;
        if ({req, addr} !== {1'b1, 32'h40}) begin
            miscompares++;
            $display("FAIL resume_req: got req=%b addr=%h expected 1 40", req, addr);
        end
        wait_valid(found);
        vectors++;
        if ({found, pc, inst_err} !== {1'b1, 32'h40, 1'b0}) begin
            miscompares++;
            $display("FAIL resume_fetch: got found=%b pc=%h err=%b expected 1 40 0", found, pc, inst_err);
        end
    endtask

    task automatic test_gnt_stall();
        int bad;
        int n;
        logic [31:0] seen[4];
        gnt = 1'b0; id_ready = 1'b1; resp_en = 1'b1;
        do_flush(32'h300);
        repeat (6) tick();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({req, addr} !== {1'b1, 32'h300}) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL addr_hold: got %0d unstable cycles expected 0", bad);
        end
        gnt = 1'b1;
        n = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                seen[n] = pc;
                n++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= n || seen[k] !== 32'h300 + 32'(4 * k)) begin
                miscompares++;
                $display("FAIL no_duplicates: entry %0d got %h (of %0d) expected %h",
                         k, seen[k], n, 32'h300 + 32'(4 * k));
            end
        end
        tick();
        gnt = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL all_delivered: got %0d undelivered expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset_startup();
        test_backpressure();
        test_flush_inflight();
        test_flush_with_rvalid();
        test_bus_error();
        test_gnt_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
